sw_pe_scheduler: RTL and testbench
==================================

Name: sw_pe_scheduler

Overview:
Sequences one affine-gap alignment PE over a full len_a x len_b DP matrix, one cell per clock, in row-major order. Holds both gene sequences in local memories and keeps one row of top scores (v, d) plus the left/diagonal registers. Drives the PE's combinational inputs and captures its v/i/d scores and direction bits. Streams per-cell direction codes to the traceback/storage logic and tracks the maximum v score and its position.

Parameters:
SCORE_W, 14, signed score width; must match the PE.
MAX_LEN, 64, maximum sequence length.
ADDR_W, 6, log2(MAX_LEN).
NEG_INF, -4096, boundary value for i/d gap scores; sized to avoid overflow under gap penalties.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_load_we  in  1  sequence memory write strobe
i_load_sel  in  1  0 = sequence A (rows), 1 = sequence B (columns)
i_load_addr  in  ADDR_W  write address
i_load_base  in  2  base code
i_len_a  in  ADDR_W+1  rows; sampled on accepted start
i_len_b  in  ADDR_W+1  columns; sampled on accepted start
i_start  in  1  start pulse
o_busy  out  1  high from accepted start until the done cycle inclusive
o_done  out  1  one-cycle completion pulse
o_pe_A, o_pe_B  out  2  bases to PE
o_pe_v_diag, o_pe_v_top, o_pe_v_left, o_pe_i_left, o_pe_d_top  out  SCORE_W  PE score inputs
i_pe_v_score, i_pe_i_score, i_pe_d_score  in  SCORE_W  PE outputs (combinational, same cycle)
i_pe_v_direct  in  2;  i_pe_i_direct, i_pe_d_direct  in  1  PE direction bits
o_dir_valid  out  1  direction stream valid
o_dir  out  4  {v_direct, i_direct, d_direct}
o_dir_row, o_dir_col  out  ADDR_W  cell coordinates of o_dir
o_max_score  out  SCORE_W  running maximum v score (signed)
o_max_row, o_max_col  out  ADDR_W  coordinates of maximum

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n. Reset puts the FSM in IDLE. o_busy, o_done, o_dir_valid and o_dir are 0; row/col/max outputs are 0. Sequence memories and row buffers are not reset and keep their contents.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Loads are accepted here only; writes while busy are ignored.
  - i_start latches the lengths. Each length is clamped to MAX_LEN.
  - Start clears r, c, max score, max row and max col to 0.
  - Next state is RUN. If either length is 0, next state is DONE directly, with no o_dir_valid and max = 0.
- RUN, cell (r,c) per cycle:
  - o_pe_A = seqA[r]; o_pe_B = seqB[c].
  - o_pe_v_top = (r==0) ? 0 : vbuf[c]; o_pe_d_top = (r==0) ? NEG_INF : dbuf[c].
  - o_pe_v_left = (c==0) ? 0 : vleft_reg; o_pe_i_left = (c==0) ? NEG_INF : ileft_reg.
  - o_pe_v_diag = (r==0 or c==0) ? 0 : diag_reg.
- RUN, clock edge:
  - vbuf[c] <= i_pe_v_score; dbuf[c] <= i_pe_d_score.
  - diag_reg <= pre-write o_pe_v_top.
  - vleft_reg <= v_score; ileft_reg <= i_score.
- Indexing: c increments. At c == len_b-1, c wraps to 0 and r increments. After cell (len_a-1, len_b-1), next state is DONE.
- Direction stream:
  - o_dir, o_dir_row, o_dir_col and o_dir_valid are registered: cell computed in cycle k appears in cycle k+1.
  - No backpressure; the consumer must accept every cycle.
- Max tracking: update only when signed v_score > current max (strict). Ties keep the earliest cell in row-major order.
- DONE, one cycle:
  - o_done = 1, o_busy = 1.
  - The last cell's o_dir_valid appears in this same cycle.
  - Max outputs are final and hold until the next start.
  - Next state is IDLE.
- i_start while busy is ignored. Reset mid-RUN aborts immediately; no o_done is produced.
- Scores pass through unmodified; no saturation in this block.

Test Plan:
All tests use a stub PE: v = max(0, v_diag + (A==B ? 2 : -1)); i = d = NEG_INF; v_direct = 2'b01 on match, else 0.
- Reset: assert rst_n=0 mid-RUN -> busy, done and dir_valid drop asynchronously. After release, a new start runs normally.
- A=B="ACGT" (0,1,2,3), lengths 4/4 -> exactly 16 o_dir_valid. Coordinates run (0,0),(0,1)…(3,3). o_done in the cycle of the 16th valid. max=8 at (3,3). Busy spans 18 cycles: 16 RUN + DONE + latch cycle counted from start edge.
- Lengths 2/3, A="AA", B="CAA" -> valid order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). v sequence 0,2,2,0,2,4. max=4 at (1,2); tie at 2 keeps (0,1) until overwritten.
- Boundary feed check on cell (1,0) -> o_pe_v_left=0, o_pe_i_left=NEG_INF, o_pe_v_diag=0. On (0,c) -> v_top=0, d_top=NEG_INF.
- i_len_a=0 -> DONE next cycle, no dir_valid, max=0. i_start and load writes during RUN are ignored; memory is unchanged, verified by rerun.
- Lengths 64/64 with all bases 0 -> 4096 valids. max = 128 at (63,63). Column wrap is correct at c=63.

Source files
------------

// File: rtl/sw_pe_scheduler.sv
// Drives one affine-gap alignment PE across a len_a x len_b DP matrix, one cell per clock in row-major order.
// Holds both sequences plus one row of top scores, streams direction codes, and tracks the best v score.
module sw_pe_scheduler #(
  parameter int SCORE_W = 14,
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6,
  parameter int NEG_INF = -4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load_we,
  input  logic                      i_load_sel,
  input  logic [ADDR_W-1:0]         i_load_addr,
  input  logic [1:0]                i_load_base,
  input  logic [ADDR_W:0]           i_len_a,
  input  logic [ADDR_W:0]           i_len_b,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_pe_A,
  output logic [1:0]                o_pe_B,
  output logic signed [SCORE_W-1:0] o_pe_v_diag,
  output logic signed [SCORE_W-1:0] o_pe_v_top,
  output logic signed [SCORE_W-1:0] o_pe_v_left,
  output logic signed [SCORE_W-1:0] o_pe_i_left,
  output logic signed [SCORE_W-1:0] o_pe_d_top,
  input  logic signed [SCORE_W-1:0] i_pe_v_score,
  input  logic signed [SCORE_W-1:0] i_pe_i_score,
  input  logic signed [SCORE_W-1:0] i_pe_d_score,
  input  logic [1:0]                i_pe_v_direct,
  input  logic                      i_pe_i_direct,
  input  logic                      i_pe_d_direct,
  output logic                      o_dir_valid,
  output logic [3:0]                o_dir,
  output logic [ADDR_W-1:0]         o_dir_row,
  output logic [ADDR_W-1:0]         o_dir_col,
  output logic signed [SCORE_W-1:0] o_max_score,
  output logic [ADDR_W-1:0]         o_max_row,
  output logic [ADDR_W-1:0]         o_max_col
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic signed [SCORE_W-1:0] NegInf = SCORE_W'(NEG_INF);
  localparam logic [ADDR_W:0]           MaxLen = (ADDR_W+1)'(MAX_LEN);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
  logic [ADDR_W:0] lenA_q, lenA_d, lenB_q, lenB_d;
  logic [ADDR_W:0] clampA, clampB;
  logic signed [SCORE_W-1:0] max_q, max_d;
  logic [ADDR_W-1:0] maxRow_q, maxRow_d, maxCol_q, maxCol_d;
  logic lastCol, lastRow;

  logic dirValid_q;
  logic [3:0] dir_q;
  logic [ADDR_W-1:0] dirRow_q, dirCol_q;

  logic [1:0] seqA [MAX_LEN];
  logic [1:0] seqB [MAX_LEN];
  logic signed [SCORE_W-1:0] vbuf [MAX_LEN];
  logic signed [SCORE_W-1:0] dbuf [MAX_LEN];
  logic signed [SCORE_W-1:0] diag_q, vLeft_q, iLeft_q;
  logic signed [SCORE_W-1:0] vTop;

  assign clampA  = (i_len_a > MaxLen) ? MaxLen : i_len_a;
  assign clampB  = (i_len_b > MaxLen) ? MaxLen : i_len_b;
  assign lastCol = ({1'b0, c_q} == lenB_q - (ADDR_W+1)'(1));
  assign lastRow = ({1'b0, r_q} == lenA_q - (ADDR_W+1)'(1));

  // Row 0 and column 0 see the matrix boundary instead of stored neighbours.
  assign vTop        = (r_q == '0) ? '0 : vbuf[c_q];
  assign o_pe_A      = seqA[r_q];
  assign o_pe_B      = seqB[c_q];
  assign o_pe_v_top  = vTop;
  assign o_pe_d_top  = (r_q == '0) ? NegInf : dbuf[c_q];
  assign o_pe_v_left = (c_q == '0) ? '0 : vLeft_q;
  assign o_pe_i_left = (c_q == '0) ? NegInf : iLeft_q;
  assign o_pe_v_diag = (r_q == '0 || c_q == '0) ? '0 : diag_q;

  assign o_busy      = (state_q != IDLE) || i_start;
  assign o_done      = (state_q == DONE);
  assign o_dir_valid = dirValid_q;
  assign o_dir       = dir_q;
  assign o_dir_row   = dirRow_q;
  assign o_dir_col   = dirCol_q;
  assign o_max_score = max_q;
  assign o_max_row   = maxRow_q;
  assign o_max_col   = maxCol_q;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    lenA_d   = lenA_q;
    lenB_d   = lenB_q;
    max_d    = max_q;
    maxRow_d = maxRow_q;
    maxCol_d = maxCol_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          lenA_d   = clampA;
          lenB_d   = clampB;
          r_d      = '0;
          c_d      = '0;
          max_d    = '0;
          maxRow_d = '0;
          maxCol_d = '0;
          state_d  = (clampA == '0 || clampB == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Strict compare keeps the earliest cell on ties.
        if (i_pe_v_score > max_q) begin
          max_d    = i_pe_v_score;
          maxRow_d = r_q;
          maxCol_d = c_q;
        end
        if (lastCol) begin
          c_d = '0;
          if (lastRow) state_d = DONE;
          else         r_d = r_q + ADDR_W'(1);
        end else begin
          c_d = c_q + ADDR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      lenA_q     <= '0;
      lenB_q     <= '0;
      max_q      <= '0;
      maxRow_q   <= '0;
      maxCol_q   <= '0;
      dirValid_q <= 1'b0;
      dir_q      <= '0;
      dirRow_q   <= '0;
      dirCol_q   <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      lenA_q     <= lenA_d;
      lenB_q     <= lenB_d;
      max_q      <= max_d;
      maxRow_q   <= maxRow_d;
      maxCol_q   <= maxCol_d;
      dirValid_q <= (state_q == RUN);
      if (state_q == RUN) begin
        dir_q    <= {i_pe_v_direct, i_pe_i_direct, i_pe_d_direct};
        dirRow_q <= r_q;
        dirCol_q <= c_q;
      end
    end
  end

  // Storage is deliberately unreset so sequences survive a reset between runs.
  always_ff @(posedge clk) begin
    if (i_load_we && state_q == IDLE) begin
      if (i_load_sel) seqB[i_load_addr] <= i_load_base;
      else            seqA[i_load_addr] <= i_load_base;
    end
    if (state_q == RUN) begin
      vbuf[c_q] <= i_pe_v_score;
      dbuf[c_q] <= i_pe_d_score;
      diag_q    <= vTop;
      vLeft_q   <= i_pe_v_score;
      iLeft_q   <= i_pe_i_score;
    end
  end

endmodule

// File: tb/tb_sw_pe_scheduler.sv
// Scoreboard bench for sw_pe_scheduler driven by a stub PE (match +2, mismatch -1, floor 0).
module tb_sw_pe_scheduler;
  localparam int SCORE_W = 14;
  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;
  localparam int NEG_INF = -4096;

  logic clk = 1'b0;
  logic rst_n;
  logic i_load_we, i_load_sel, i_start;
  logic [ADDR_W-1:0] i_load_addr;
  logic [1:0] i_load_base;
  logic [ADDR_W:0] i_len_a, i_len_b;
  logic o_busy, o_done, o_dir_valid;
  logic [1:0] o_pe_A, o_pe_B;
  logic signed [SCORE_W-1:0] o_pe_v_diag, o_pe_v_top, o_pe_v_left, o_pe_i_left, o_pe_d_top;
  logic signed [SCORE_W-1:0] i_pe_v_score, i_pe_i_score, i_pe_d_score;
  logic [1:0] i_pe_v_direct;
  logic i_pe_i_direct, i_pe_d_direct;
  logic [3:0] o_dir;
  logic [ADDR_W-1:0] o_dir_row, o_dir_col, o_max_row, o_max_col;
  logic signed [SCORE_W-1:0] o_max_score;

  typedef struct {
    int row; int col; int dir; int maxScore; int maxRow; int maxCol; bit last;
  } cell_t;
  cell_t expQ[$];
  int checkCount = 0;
  int errorCount = 0;
  int stubSum;

  sw_pe_scheduler #(.SCORE_W(SCORE_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .NEG_INF(NEG_INF)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_load_we(i_load_we), .i_load_sel(i_load_sel), .i_load_addr(i_load_addr), .i_load_base(i_load_base),
    .i_len_a(i_len_a), .i_len_b(i_len_b), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done),
    .o_pe_A(o_pe_A), .o_pe_B(o_pe_B),
    .o_pe_v_diag(o_pe_v_diag), .o_pe_v_top(o_pe_v_top), .o_pe_v_left(o_pe_v_left),
    .o_pe_i_left(o_pe_i_left), .o_pe_d_top(o_pe_d_top),
    .i_pe_v_score(i_pe_v_score), .i_pe_i_score(i_pe_i_score), .i_pe_d_score(i_pe_d_score),
    .i_pe_v_direct(i_pe_v_direct), .i_pe_i_direct(i_pe_i_direct), .i_pe_d_direct(i_pe_d_direct),
    .o_dir_valid(o_dir_valid), .o_dir(o_dir), .o_dir_row(o_dir_row), .o_dir_col(o_dir_col),
    .o_max_score(o_max_score), .o_max_row(o_max_row), .o_max_col(o_max_col)
  );

  always #5 clk = ~clk;

  // Stub PE: combinational, same cycle as the scheduler's feeds.
  always_comb begin
    stubSum       = int'(o_pe_v_diag) + ((o_pe_A == o_pe_B) ? 2 : -1);
    i_pe_v_score  = (stubSum > 0) ? SCORE_W'(stubSum) : '0;
    i_pe_v_direct = (o_pe_A == o_pe_B) ? 2'b01 : 2'b00;
  end
  assign i_pe_i_score  = SCORE_W'(NEG_INF);
  assign i_pe_d_score  = SCORE_W'(NEG_INF);
  assign i_pe_i_direct = 1'b0;
  assign i_pe_d_direct = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input int addr, input int base);
    @(posedge clk); #1;
    i_load_we   = 1'b1;
    i_load_sel  = sel;
    i_load_addr = addr[ADDR_W-1:0];
    i_load_base = base[1:0];
    @(posedge clk); #1;
    i_load_we   = 1'b0;
  endtask

  task automatic pushCell(input int r, input int c, input int dir, input int mx,
                          input int mr, input int mc, input bit last);
    cell_t e;
    e.row = r; e.col = c; e.dir = dir; e.maxScore = mx; e.maxRow = mr; e.maxCol = mc; e.last = last;
    expQ.push_back(e);
  endtask

  // Square runs where off-diagonal cells never beat the diagonal: the best cell so far
  // is the latest diagonal (k,k) reached in row-major order, with score 2*(k+1).
  task automatic pushDiagRun(input int n, input bit allMatch);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        int k;
        k = (c >= r) ? r : r - 1;
        pushCell(r, c, (allMatch || r == c) ? 4 : 0, 2 * (k + 1), k, k, (r == n - 1 && c == n - 1));
      end
    end
  endtask

  task automatic startRun(input int la, input int lb, input bit feedCheck, input bit disturb,
                          output int busyCycles, output bit sawDone);
    int cells;
    cells = la * lb;
    busyCycles = 0;
    sawDone = 1'b0;
    @(posedge clk); #1;
    i_len_a = la[ADDR_W:0];
    i_len_b = lb[ADDR_W:0];
    i_start = 1'b1;
    for (int t = 0; t < cells + 10 && !sawDone; t++) begin
      @(negedge clk);
      if (o_busy) busyCycles++;
      if (o_done) sawDone = 1'b1;
      if (feedCheck && t >= 1 && t <= cells) begin
        int r, c;
        r = (t - 1) / lb;
        c = (t - 1) % lb;
        checkOutput("feed_i_left", int'(o_pe_i_left), NEG_INF);
        checkOutput("feed_d_top", int'(o_pe_d_top), NEG_INF);
        if (r == 0) checkOutput("feed_v_top_row0", int'(o_pe_v_top), 0);
        if (c == 0) begin
          checkOutput("feed_v_left_col0", int'(o_pe_v_left), 0);
          checkOutput("feed_v_diag_col0", int'(o_pe_v_diag), 0);
        end
      end
      @(posedge clk); #1;
      i_start   = 1'b0;
      i_load_we = 1'b0;
      if (disturb && t == 2) begin
        i_start     = 1'b1;
        i_len_a     = 7'd1;
        i_load_we   = 1'b1;
        i_load_sel  = 1'b0;
        i_load_addr = '0;
        i_load_base = 2'd1;
      end
    end
    if (!sawDone) begin
      errorCount++;
      checkCount++;
      $display("[TB] FAIL done_timeout: got no o_done, expected one within %0d cycles", cells + 10);
    end
  endtask

  // Monitor: every presented direction beat is matched against the scoreboard head.
  always @(negedge clk) begin
    cell_t e;
    if (rst_n && o_dir_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected_dir: got cell (%0d,%0d), expected no beat", o_dir_row, o_dir_col);
      end else begin
        e = expQ.pop_front();
        checkOutput("dir_row", int'(o_dir_row), e.row);
        checkOutput("dir_col", int'(o_dir_col), e.col);
        checkOutput("dir_code", int'(o_dir), e.dir);
        checkOutput("max_score", int'(o_max_score), e.maxScore);
        checkOutput("max_row", int'(o_max_row), e.maxRow);
        checkOutput("max_col", int'(o_max_col), e.maxCol);
        checkOutput("done_with_last", int'(o_done), int'(e.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy;
    bit done;
    rst_n = 1'b0;
    i_load_we = 1'b0; i_load_sel = 1'b0; i_load_addr = '0; i_load_base = '0;
    i_len_a = '0; i_len_b = '0; i_start = 1'b0;
    #12;
    checkOutput("reset_busy", int'(o_busy), 0);
    checkOutput("reset_done", int'(o_done), 0);
    checkOutput("reset_dir_valid", int'(o_dir_valid), 0);
    checkOutput("reset_dir", int'(o_dir), 0);
    checkOutput("reset_max", int'(o_max_score), 0);
    checkOutput("reset_max_row", int'(o_max_row), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, i, i);
      applyStimulus(1'b1, i, i);
    end

    $display("[TB] reset abort mid-run");
    pushDiagRun(4, 1'b0);
    @(posedge clk); #1;
    i_len_a = 7'd4; i_len_b = 7'd4; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(o_busy), 0);
    checkOutput("abort_done", int'(o_done), 0);
    checkOutput("abort_dir_valid", int'(o_dir_valid), 0);
    checkOutput("abort_max", int'(o_max_score), 0);
    expQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", int'(o_done), 0);
    end

    $display("[TB] ACGT x ACGT");
    pushDiagRun(4, 1'b0);
    startRun(4, 4, 1'b1, 1'b0, busy, done);
    checkOutput("acgt_busy_cycles", busy, 18);
    checkOutput("acgt_queue_drained", expQ.size(), 0);
    @(negedge clk);
    checkOutput("acgt_max_hold", int'(o_max_score), 8);
    checkOutput("acgt_max_row_hold", int'(o_max_row), 3);

    $display("[TB] AA x CAA with ignored start/load during run");
    applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b0, 1, 0);
    applyStimulus(1'b1, 0, 1);
    applyStimulus(1'b1, 1, 0);
    applyStimulus(1'b1, 2, 0);
    for (int pass = 0; pass < 2; pass++) begin
      pushCell(0, 0, 0, 0, 0, 0, 1'b0);
      pushCell(0, 1, 4, 2, 0, 1, 1'b0);
      pushCell(0, 2, 4, 2, 0, 1, 1'b0);
      pushCell(1, 0, 0, 2, 0, 1, 1'b0);
      pushCell(1, 1, 4, 2, 0, 1, 1'b0);
      pushCell(1, 2, 4, 4, 1, 2, 1'b1);
      startRun(2, 3, 1'b1, (pass == 0), busy, done);
      checkOutput("aa_busy_cycles", busy, 8);
      checkOutput("aa_queue_drained", expQ.size(), 0);
    end

    $display("[TB] zero length");
    startRun(0, 3, 1'b0, 1'b0, busy, done);
    checkOutput("zero_busy_cycles", busy, 2);
    checkOutput("zero_done", int'(done), 1);
    checkOutput("zero_max", int'(o_max_score), 0);
    checkOutput("zero_max_row", int'(o_max_row), 0);
    checkOutput("zero_max_col", int'(o_max_col), 0);

    $display("[TB] 64 x 64 all zero bases");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, i, 0);
      applyStimulus(1'b1, i, 0);
    end
    pushDiagRun(64, 1'b1);
    startRun(64, 64, 1'b0, 1'b0, busy, done);
    checkOutput("full_busy_cycles", busy, 4098);
    checkOutput("full_queue_drained", expQ.size(), 0);
    @(negedge clk);
    checkOutput("full_max", int'(o_max_score), 128);
    checkOutput("full_max_row", int'(o_max_row), 63);
    checkOutput("full_max_col", int'(o_max_col), 63);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
